// File: rtl/cond_logic_if.sv
// cond_logic_if -- bundle between the instruction decoder and the
// conditional-execution stage.
//
// Signals:
//   Valid              instruction is real (0 = bubble/stall)
//   Cond               Instr[31:28] condition field
//   ALUFlags           {N,Z,C,V} produced by the ALU for this instruction
//   FlagW              [1] write N,Z ; [0] write C,V
//   PCS/RegW/MemW      raw decoder write intents
//   NoWrite            compare/test class, suppresses register write
//   PCSrc/RegWrite/MemWrite  gated write enables
//   CondEx             condition satisfied by the registered flags
//   Flags              registered {N,Z,C,V}
//   ExecCnt/SkipCnt    debug statistics counters (CNT_W bits)
//
// Modports: master = decoder/datapath side, slave = cond_logic.
interface cond_logic_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SkipCnt;

  modport master (
    output Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCnt, SkipCnt
  );

  modport slave (
    input  Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCnt, SkipCnt
  );
endinterface

// File: rtl/cond_logic.sv
// cond_logic -- conditional-execution stage of the single-cycle ARM
// calculator datapath. Evaluates the condition field against the
// registered NZCV flags, gates PC/register/memory write enables and
// updates the flag register from the ALU for executed instructions.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high reset
//   bus    cond_logic_if.slave (see interface for signal list)
//
// Configuration:
//   COND_STATS_EN  when defined, ExecCnt/SkipCnt are saturating counters of
//                  executed / condition-failed valid instructions; otherwise
//                  both are tied to zero and no counter state exists.
module cond_logic #(
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  cond_logic_if.slave bus
);

  // Flag register kept as two independently written fields.
  logic [1:0] nzQ;
  logic [1:0] cvQ;
  logic       condEx;
  logic       nFlag, zFlag, cFlag, vFlag;

  assign nFlag = nzQ[1];
  assign zFlag = nzQ[0];
  assign cFlag = cvQ[1];
  assign vFlag = cvQ[0];

  // Condition decode uses only the registered flags, so an instruction's own
  // flag write can never influence its own execution.
  always_comb begin
    condEx = 1'b0;
    case (bus.Cond)
      4'b0000: condEx = zFlag;
      4'b0001: condEx = ~zFlag;
      4'b0010: condEx = cFlag;
      4'b0011: condEx = ~cFlag;
      4'b0100: condEx = nFlag;
      4'b0101: condEx = ~nFlag;
      4'b0110: condEx = vFlag;
      4'b0111: condEx = ~vFlag;
      4'b1000: condEx = cFlag & ~zFlag;
      4'b1001: condEx = ~cFlag | zFlag;
      4'b1010: condEx = (nFlag == vFlag);
      4'b1011: condEx = (nFlag != vFlag);
      4'b1100: condEx = ~zFlag & (nFlag == vFlag);
      4'b1101: condEx = zFlag | (nFlag != vFlag);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;  // 1111 reserved: never execute
    endcase
  end

  always_comb begin
    bus.CondEx   = condEx;
    bus.PCSrc    = bus.PCS & condEx & bus.Valid;
    bus.RegWrite = bus.RegW & condEx & bus.Valid & ~bus.NoWrite;
    bus.MemWrite = bus.MemW & condEx & bus.Valid;
    bus.Flags    = {nzQ, cvQ};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nzQ <= '0;
      cvQ <= '0;
    end else if (bus.Valid && condEx) begin
      if (bus.FlagW[1]) nzQ <= bus.ALUFlags[3:2];
      if (bus.FlagW[0]) cvQ <= bus.ALUFlags[1:0];
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] execQ;
  logic [CNT_W-1:0] skipQ;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      execQ <= '0;
      skipQ <= '0;
    end else if (bus.Valid) begin
      if (condEx) begin
        if (execQ != '1) execQ <= execQ + 1'b1;
      end else begin
        if (skipQ != '1) skipQ <= skipQ + 1'b1;
      end
    end
  end

  assign bus.ExecCnt = execQ;
  assign bus.SkipCnt = skipQ;
`else
  assign bus.ExecCnt = '0;
  assign bus.SkipCnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: a driver issues directed and random
// instructions, a reference model predicts the combinational response of each
// cycle and queues it; a monitor pops and compares on the falling edge.
module tb_cond_logic;
  localparam int unsigned CW = 2;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef COND_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic       pcSrc;
    logic       regWrite;
    logic       memWrite;
    logic       condEx;
    logic [3:0] flags;
    int unsigned execCnt;
    int unsigned skipCnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  // Reference model state
  logic [3:0]  mFlags;
  int unsigned mExec;
  int unsigned mSkip;

  cond_logic_if #(.CNT_W(CW)) bus ();
  cond_logic #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Condition = predicate chosen by Cond[3:1], inverted by Cond[0];
  // 1111 is the lone exception (never).
  function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit valid, input logic [3:0] cond,
                      input logic [3:0] alu, input logic [1:0] flagw,
                      input bit pcs, input bit regw, input bit memw,
                      input bit noWrite, input bit chk);
    exp_t e;
    bit   ex;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.Valid    = valid;
    bus.Cond     = cond;
    bus.ALUFlags = alu;
    bus.FlagW    = flagw;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = noWrite;
    ex = condHolds(cond, mFlags);
    e.condEx   = ex;
    e.pcSrc    = pcs && ex && valid;
    e.regWrite = regw && ex && valid && !noWrite;
    e.memWrite = memw && ex && valid;
    e.flags    = mFlags;
    e.execCnt  = STATS ? mExec : 0;
    e.skipCnt  = STATS ? mSkip : 0;
    if (chk) expQ.push_back(e);
    if (rst) begin
      mFlags = 4'b0000; mExec = 0; mSkip = 0;
    end else if (valid) begin
      if (ex) begin
        if (flagw[1]) mFlags[3:2] = alu[3:2];
        if (flagw[0]) mFlags[1:0] = alu[1:0];
        if (mExec < CNT_MAX) mExec++;
      end else if (mSkip < CNT_MAX) begin
        mSkip++;
      end
    end
  endtask

  // Monitor: outputs are settled half a cycle after the driver updates inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cmp("CondEx",   bus.CondEx,   e.condEx);
        cmp("PCSrc",    bus.PCSrc,    e.pcSrc);
        cmp("RegWrite", bus.RegWrite, e.regWrite);
        cmp("MemWrite", bus.MemWrite, e.memWrite);
        cmp("Flags",    bus.Flags,    e.flags);
        cmp("ExecCnt",  bus.ExecCnt,  e.execCnt);
        cmp("SkipCnt",  bus.SkipCnt,  e.skipCnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.Valid = 1'b0; bus.Cond = '0; bus.ALUFlags = '0; bus.FlagW = '0;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
    mFlags = '0; mExec = 0; mSkip = 0;

    // Initial reset: DUT state unknown during this cycle, so not checked.
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    // CondEx for every condition with reset flags (bubbles, no state change).
    for (int i = 0; i < 16; i++)
      step(0, 0, 4'(i), 4'hF, 2'b11, 1, 1, 1, 0, 1);
    step(0, 1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1);       // EQ, Z=0 -> skip
    step(0, 1, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0, 1);       // NE -> exec
    step(0, 1, 4'hE, 4'h6, 2'b11, 0, 1, 0, 0, 1);       // SUBS
    step(0, 1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 1);       // BEQ taken
    step(0, 1, 4'hE, 4'h8, 2'b10, 0, 1, 0, 0, 1);       // ANDS keeps C,V
    step(0, 1, 4'hE, 4'h4, 2'b11, 0, 1, 0, 0, 1);       // flags -> 0100
    step(0, 1, 4'h1, 4'h3, 2'b11, 0, 1, 0, 0, 1);       // ADDSNE fails
    step(0, 1, 4'hE, 4'h9, 2'b11, 0, 1, 0, 1, 1);       // CMP
    step(0, 0, 4'hE, 4'h5, 2'b11, 0, 1, 1, 0, 1);       // bubble with MemW
    step(0, 1, 4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 1);       // reserved cond
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(0, 1, 4'hE, 4'(i), 2'b11, 0, 1, 1, 0, 1);    // saturate ExecCnt
    step(1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 1);       // reset beats flag write
    step(0, 1, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
           4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    cmp("QueueDrained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
